// File: rtl/mother_base_ctrl.sv
// rtl/mother_base_ctrl.sv - mother base hit/health sequencer for the VGA playfield
//
// Purpose: arbitrates bullet-hit pulses from both player tanks against a shared
// health counter and sequences the base through ALIVE, FLASH, DYING and DEAD.
// Drives the colour/visibility of the base square object and raises game-over.
// Time is counted in video frames via startOfFrame.
//
// Optional feature macro: MOTHER_BASE_REGEN_EN (health regeneration in ALIVE).
//
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous active-high reset
//   startOfFrame in   one-cycle pulse per video frame
//   hitP1        in   one-cycle pulse, player-1 bullet hit the base
//   hitP2        in   one-cycle pulse, player-2 bullet hit the base
//   restart      in   one-cycle pulse, new game
//   baseColor    out  colour for the square object (registered)
//   baseVisible  out  square object may draw (registered)
//   health       out  current health (registered)
//   lastHitter   out  {P2,P1} of the most recent accepted hit, 00 = none
//   gameOver     out  high while DEAD (registered)

module mother_base_ctrl #(
  parameter int          MAX_HEALTH   = 4,
  parameter int          FLASH_FRAMES = 8,
  parameter int          DYING_FRAMES = 30,
  parameter int          REGEN_FRAMES = 120,
  parameter logic [7:0]  NORMAL_COLOR = 8'h5b,
  parameter logic [7:0]  FLASH_COLOR  = 8'hE0,
  parameter logic [7:0]  DYING_COLOR  = 8'hE4,
  parameter logic [7:0]  DEAD_COLOR   = 8'h49
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       hitP1,
  input  logic       hitP2,
  input  logic       restart,
  output logic [7:0] baseColor,
  output logic       baseVisible,
  output logic [3:0] health,
  output logic [1:0] lastHitter,
  output logic       gameOver
);

  typedef enum logic [1:0] {ALIVE, FLASH, DYING, DEAD} state_t;

  localparam logic [3:0] MAX_LOAD   = MAX_HEALTH[3:0];
  localparam logic [7:0] FLASH_LOAD = FLASH_FRAMES[7:0];
  localparam logic [7:0] DIE_LOAD   = DYING_FRAMES[7:0];

  state_t     state, state_nxt;
  logic [3:0] health_nxt;
  logic [1:0] last_nxt;
  logic [7:0] flash_cnt, flash_nxt;
  logic       phase, phase_nxt;
  logic [7:0] die_cnt, die_nxt;
  logic       die_vis, die_vis_nxt;
  logic [7:0] color_nxt;
  logic       visible_nxt;

  logic       hit;
  logic [1:0] hit_n;
  logic [3:0] health_sub;

`ifdef MOTHER_BASE_REGEN_EN
  localparam logic [7:0] REGEN_LOAD = REGEN_FRAMES[7:0];
  logic [7:0] regen_cnt, regen_nxt;
`endif

  assign hit   = hitP1 | hitP2;
  assign hit_n = {1'b0, hitP1} + {1'b0, hitP2};
  // Saturating subtract: a double hit at health 1 lands on 0, never wraps.
  assign health_sub = (health > {2'b00, hit_n}) ? (health - {2'b00, hit_n}) : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALIVE;
      health      <= MAX_LOAD;
      lastHitter  <= 2'b00;
      flash_cnt   <= 8'd0;
      phase       <= 1'b0;
      die_cnt     <= 8'd0;
      die_vis     <= 1'b1;
      baseColor   <= NORMAL_COLOR;
      baseVisible <= 1'b1;
      gameOver    <= 1'b0;
`ifdef MOTHER_BASE_REGEN_EN
      regen_cnt   <= 8'd0;
`endif
    end else begin
      state       <= state_nxt;
      health      <= health_nxt;
      lastHitter  <= last_nxt;
      flash_cnt   <= flash_nxt;
      phase       <= phase_nxt;
      die_cnt     <= die_nxt;
      die_vis     <= die_vis_nxt;
      baseColor   <= color_nxt;
      baseVisible <= visible_nxt;
      gameOver    <= (state_nxt == DEAD);
`ifdef MOTHER_BASE_REGEN_EN
      regen_cnt   <= regen_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    health_nxt  = health;
    last_nxt    = lastHitter;
    flash_nxt   = flash_cnt;
    phase_nxt   = phase;
    die_nxt     = die_cnt;
    die_vis_nxt = die_vis;
`ifdef MOTHER_BASE_REGEN_EN
    // Regen only accumulates in ALIVE; every other state holds it cleared.
    regen_nxt   = 8'd0;
`endif

    if (restart) begin
      state_nxt   = ALIVE;
      health_nxt  = MAX_LOAD;
      last_nxt    = 2'b00;
      flash_nxt   = 8'd0;
      phase_nxt   = 1'b0;
      die_nxt     = 8'd0;
      die_vis_nxt = 1'b1;
    end else begin
      case (state)
        ALIVE, FLASH: begin
          if (hit) begin
            // A hit outranks a coincident frame tick, which is dropped.
            health_nxt = health_sub;
            last_nxt   = {hitP2, hitP1};
            phase_nxt  = 1'b0;
            if (health_sub == 4'd0) begin
              state_nxt   = DYING;
              flash_nxt   = 8'd0;
              die_nxt     = DIE_LOAD;
              die_vis_nxt = 1'b1;
            end else begin
              state_nxt = FLASH;
              flash_nxt = FLASH_LOAD;
            end
          end else if (state == FLASH) begin
            if (startOfFrame) begin
              flash_nxt = flash_cnt - 8'd1;
              phase_nxt = ~phase;
              if (flash_cnt == 8'd1) begin
                state_nxt = ALIVE;
                phase_nxt = 1'b0;
              end
            end
          end else begin
`ifdef MOTHER_BASE_REGEN_EN
            regen_nxt = regen_cnt;
            if (health == MAX_LOAD) begin
              regen_nxt = 8'd0;
            end else if (startOfFrame) begin
              if (regen_cnt + 8'd1 == REGEN_LOAD) begin
                health_nxt = health + 4'd1;
                regen_nxt  = 8'd0;
              end else begin
                regen_nxt = regen_cnt + 8'd1;
              end
            end
`endif
          end
        end
        DYING: begin
          if (startOfFrame) begin
            die_nxt     = die_cnt - 8'd1;
            die_vis_nxt = ~die_vis;
            if (die_cnt == 8'd1) begin
              state_nxt   = DEAD;
              die_vis_nxt = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Outputs are decoded from the next state so they land one edge after the event.
    visible_nxt = 1'b1;
    case (state_nxt)
      ALIVE:   color_nxt = NORMAL_COLOR;
      FLASH:   color_nxt = phase_nxt ? NORMAL_COLOR : FLASH_COLOR;
      DYING: begin
        color_nxt   = DYING_COLOR;
        visible_nxt = die_vis_nxt;
      end
      default: color_nxt = DEAD_COLOR;
    endcase
  end

endmodule
